uart_slot_arbiter: RTL and testbench
====================================

Name: uart_slot_arbiter

Overview:
- Shares the single MCU UART channel (UC_TXD0 / UC_RXD0) among the slot cards that carry a serial link: stepper OW_ID on C5, RS232 TX/RX on C0/C1.
- The command decoder requests a slot. The block waits for the current link to go idle, inserts an idle gap, then switches the TX fan-out and the RX mux.
- It sits between the command decoder and the slot pin-mux logic. The pin-mux logic consumes slot_tx and produces slot_rx.

Parameters:
- NUM_SLOTS, 7, number of card slots; slot codes 0..NUM_SLOTS-1.
- SEL_W, 3, width of slot select code; code 2^SEL_W-1 (7) = release/none.
- GUARD_CYCLES, 1736, consecutive idle-high clk cycles on both UC_TXD0 and the active slot_rx required before switching (2 bit times at 115200 baud, 100 MHz).
- GAP_CYCLES, 868, cycles with all TX idle and UC_RXD0 forced high between old and new slot.
- DRAIN_TIMEOUT, 1000000, maximum DRAIN cycles before a forced switch (10 ms).

Ports:
- clk  in  1  100 MHz clock
- resetn  in  1  synchronous active-low reset
- sel_valid  in  1  one-cycle select request strobe
- sel_slot  in  SEL_W  requested slot; 7 = release
- slot_uart_capable  in  NUM_SLOTS  1 = slot's current type carries a UART (stepper or RS232)
- UC_TXD0  in  1  MCU UART TX
- slot_rx  in  NUM_SLOTS  per-slot RX line from the pin mux
- UC_RXD0  out  1  muxed RX to the MCU
- slot_tx  out  NUM_SLOTS  per-slot TX to the pin mux
- active_slot  out  SEL_W  currently connected slot; 7 = none
- busy  out  1  high in DRAIN or GAP
- sel_ack  out  1  one-cycle pulse when the requested connection becomes effective
- sel_err  out  1  one-cycle pulse when a request is rejected
- sel_forced  out  1  one-cycle pulse when DRAIN timed out
- link_lost  out  1  one-cycle pulse when the active slot lost capability

Behaviour:
- Reset state:
  - state = NONE, active_slot = 7, target = 7.
  - slot_tx = all 1s, UC_RXD0 = 1.
  - busy = 0; all pulses 0; all counters 0.
- All outputs are registered.
  - slot_tx[i] = UC_TXD0 delayed 1 clk when i == active_slot and state is ACTIVE or DRAIN; otherwise 1.
  - UC_RXD0 = slot_rx[active_slot] delayed 1 clk in ACTIVE/DRAIN; otherwise 1.
- Request validation, performed in the cycle sel_valid is high:
  - Reject with sel_err if busy=1.
  - Reject with sel_err if sel_slot is not 7 and (sel_slot >= NUM_SLOTS or slot_uart_capable[sel_slot] = 0).
  - A rejected request leaves state unchanged.
- States:
  - NONE:
    - Valid request to a slot: target <= sel_slot, gap counter cleared, go GAP.
    - Valid request of 7: sel_ack next cycle, stay NONE.
  - ACTIVE:
    - Valid request equal to active_slot: sel_ack next cycle, no switch.
    - Valid request to a different slot or to 7: target <= sel_slot, idle and timeout counters cleared, go DRAIN.
    - slot_uart_capable[active_slot] falls: link_lost pulse, target <= 7, go GAP immediately without drain.
  - DRAIN:
    - Old connection stays live.
    - Idle counter increments while UC_TXD0=1 and slot_rx[active_slot]=1, and clears to 0 on any low.
    - Idle counter reaching GUARD_CYCLES: go GAP.
    - Timeout counter reaching DRAIN_TIMEOUT first: sel_forced pulse, go GAP.
    - Capability loss of the old slot: go GAP at once with link_lost pulse; target is unchanged.
  - GAP:
    - active_slot = 7 and all lines idle for GAP_CYCLES cycles.
    - Then, if target is 7: go NONE.
    - Otherwise, if slot_uart_capable[target] = 1: go ACTIVE with active_slot <= target.
    - Otherwise: sel_err, go NONE.
    - sel_ack pulses in the cycle active_slot is updated (ACTIVE entry or NONE entry on release).
- Simultaneous events:
  - Capability loss has priority over a request in the same cycle; the request gets sel_err.
- Latency: an idle switch from ACTIVE takes GUARD_CYCLES + GAP_CYCLES + 2 cycles from the sel_valid edge to sel_ack.
- Counters are sized clog2(max+1) and saturate; they never wrap.
- Reset asserted mid-DRAIN or mid-GAP returns to the reset state next clk with no pulses.

Test Plan (override parameters GUARD_CYCLES=8, GAP_CYCLES=4, DRAIN_TIMEOUT=64):
- After reset, capable=7'b0000101, sel_slot=2 -> GAP for 4 cycles, then active_slot=2 and sel_ack one pulse. Toggling UC_TXD0 then appears on slot_tx[2] one clk later; other slot_tx stay 1. slot_rx[2]=0 -> UC_RXD0=0 one clk later.
- Active=0, request slot 2 while UC_TXD0 toggles every 3 cycles for 20 cycles then holds 1 -> no switch during toggling. Switch occurs 8 idle cycles + 4 gap cycles after the last low. sel_forced=0.
- Active=0, UC_TXD0 held toggling forever, request slot 2 -> sel_forced pulse 64 cycles after entering DRAIN, then GAP and active_slot=2.
- Request slot 5 with capable[5]=0, request slot 7 while busy, and request sel_slot=6 with NUM_SLOTS=6 -> each gives a sel_err pulse; state and active_slot unchanged.
- Active=2, drop capable[2] in the same cycle as a sel_valid for slot 0 -> link_lost pulse, sel_err pulse, GAP, then NONE with active_slot=7.
- Assert resetn=0 for 1 cycle mid-DRAIN -> next cycle active_slot=7, slot_tx=all 1s, UC_RXD0=1, busy=0.

Source files
------------

// File: rtl/uart_slot_arbiter.sv
// Shares the single MCU UART (UC_TXD0/UC_RXD0) among slot cards: drains the current
// link until idle, holds an all-idle gap, then switches the TX fan-out and RX mux.
module uart_slot_arbiter #(
    parameter int NUM_SLOTS     = 7,
    parameter int SEL_W         = 3,
    parameter int GUARD_CYCLES  = 1736,
    parameter int GAP_CYCLES    = 868,
    parameter int DRAIN_TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel_slot,
    input  logic [NUM_SLOTS-1:0] slot_uart_capable,
    input  logic                 UC_TXD0,
    input  logic [NUM_SLOTS-1:0] slot_rx,
    output logic                 UC_RXD0,
    output logic [NUM_SLOTS-1:0] slot_tx,
    output logic [SEL_W-1:0]     active_slot,
    output logic                 busy,
    output logic                 sel_ack,
    output logic                 sel_err,
    output logic                 sel_forced,
    output logic                 link_lost,
    output logic [1:0]           dbg_state
);
    // Handshake: sel_valid is a one-cycle strobe with no back-pressure; each accepted
    // or rejected request is answered later by exactly one sel_ack or sel_err pulse.

    typedef enum logic [1:0] {
        ST_NONE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] SEL_NONE = '1;
    localparam int IDLE_W = $clog2(GUARD_CYCLES + 1);
    localparam int TMO_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(GUARD_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(DRAIN_TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYCLES);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   active_nx, target, target_nx;
    logic               rel_pend, rel_pend_nx;
    logic [IDLE_W-1:0]  idle_cnt, idle_nx, idle_inc;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nx, tmo_inc;
    logic [GAP_W-1:0]   gap_cnt, gap_nx, gap_inc;
    logic               ack_nx, err_nx, forced_nx, lost_nx;
    logic               rx_sel, cap_act, cap_req, cap_tgt, req_ok, live;
    logic [NUM_SLOTS-1:0] tx_nx;

    assign dbg_state = state;

    assign idle_inc = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);
    assign tmo_inc  = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    assign gap_inc  = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + GAP_W'(1);

    // Code 7 never matches a slot index, so the release code selects idle/incapable.
    always_comb begin
        rx_sel  = 1'b1;
        cap_act = 1'b0;
        cap_req = 1'b0;
        cap_tgt = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_slot == SEL_W'(i)) begin
                rx_sel  = slot_rx[i];
                cap_act = slot_uart_capable[i];
            end
            if (sel_slot == SEL_W'(i)) cap_req = slot_uart_capable[i];
            if (target == SEL_W'(i))   cap_tgt = slot_uart_capable[i];
        end
    end

    assign req_ok = (sel_slot == SEL_NONE) || cap_req;
    assign live   = (state == ST_ACTIVE) || (state == ST_DRAIN);

    always_comb begin
        tx_nx = '1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (live && active_slot == SEL_W'(i)) tx_nx[i] = UC_TXD0;
        end
    end

    always_comb begin
        state_nx    = state;
        active_nx   = active_slot;
        target_nx   = target;
        rel_pend_nx = rel_pend;
        idle_nx     = idle_cnt;
        tmo_nx      = tmo_cnt;
        gap_nx      = gap_cnt;
        ack_nx      = 1'b0;
        err_nx      = 1'b0;
        forced_nx   = 1'b0;
        lost_nx     = 1'b0;
        case (state)
            ST_NONE: begin
                if (sel_valid) begin
                    if (!req_ok) begin
                        err_nx = 1'b1;
                    end else if (sel_slot == SEL_NONE) begin
                        ack_nx = 1'b1;
                    end else begin
                        target_nx   = sel_slot;
                        rel_pend_nx = 1'b0;
                        gap_nx      = '0;
                        state_nx    = ST_GAP;
                    end
                end
            end
            ST_ACTIVE: begin
                // Capability loss outranks any request arriving in the same cycle.
                if (!cap_act) begin
                    lost_nx     = 1'b1;
                    err_nx      = sel_valid;
                    target_nx   = SEL_NONE;
                    rel_pend_nx = 1'b0;
                    active_nx   = SEL_NONE;
                    gap_nx      = '0;
                    state_nx    = ST_GAP;
                end else if (sel_valid) begin
                    if (!req_ok) begin
                        err_nx = 1'b1;
                    end else if (sel_slot == active_slot) begin
                        ack_nx = 1'b1;
                    end else begin
                        target_nx   = sel_slot;
                        rel_pend_nx = (sel_slot == SEL_NONE);
                        idle_nx     = '0;
                        tmo_nx      = '0;
                        state_nx    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                err_nx  = sel_valid;
                idle_nx = (UC_TXD0 && rx_sel) ? idle_inc : '0;
                tmo_nx  = tmo_inc;
                if (!cap_act) begin
                    lost_nx   = 1'b1;
                    active_nx = SEL_NONE;
                    gap_nx    = '0;
                    state_nx  = ST_GAP;
                end else if (idle_cnt == IDLE_MAX) begin
                    active_nx = SEL_NONE;
                    gap_nx    = '0;
                    state_nx  = ST_GAP;
                end else if (tmo_cnt == TMO_MAX) begin
                    forced_nx = 1'b1;
                    active_nx = SEL_NONE;
                    gap_nx    = '0;
                    state_nx  = ST_GAP;
                end
            end
            ST_GAP: begin
                err_nx = sel_valid;
                gap_nx = gap_inc;
                if (gap_cnt == GAP_MAX) begin
                    rel_pend_nx = 1'b0;
                    if (target == SEL_NONE) begin
                        ack_nx   = rel_pend;
                        state_nx = ST_NONE;
                    end else if (cap_tgt) begin
                        ack_nx    = 1'b1;
                        active_nx = target;
                        state_nx  = ST_ACTIVE;
                    end else begin
                        err_nx    = 1'b1;
                        target_nx = SEL_NONE;
                        state_nx  = ST_NONE;
                    end
                end
            end
            default: state_nx = ST_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_NONE;
            active_slot <= SEL_NONE;
            target      <= SEL_NONE;
            rel_pend    <= 1'b0;
            idle_cnt    <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            slot_tx     <= '1;
            UC_RXD0     <= 1'b1;
            busy        <= 1'b0;
            sel_ack     <= 1'b0;
            sel_err     <= 1'b0;
            sel_forced  <= 1'b0;
            link_lost   <= 1'b0;
        end else begin
            state       <= state_nx;
            active_slot <= active_nx;
            target      <= target_nx;
            rel_pend    <= rel_pend_nx;
            idle_cnt    <= idle_nx;
            tmo_cnt     <= tmo_nx;
            gap_cnt     <= gap_nx;
            slot_tx     <= tx_nx;
            UC_RXD0     <= live ? rx_sel : 1'b1;
            busy        <= (state_nx == ST_DRAIN) || (state_nx == ST_GAP);
            sel_ack     <= ack_nx;
            sel_err     <= err_nx;
            sel_forced  <= forced_nx;
            link_lost   <= lost_nx;
        end
    end

endmodule

// File: tb/tb_uart_slot_arbiter.sv
// Bench for uart_slot_arbiter: event-level reference model feeding an expected-event
// queue, with a monitor that pops and compares every response pulse.
module tb_uart_slot_arbiter;
    localparam int G  = 8;
    localparam int GP = 4;
    localparam int T  = 64;
    localparam logic [2:0] NONE = 3'd7;
    localparam int K_ACK = 1, K_ERR = 2, K_FORCED = 3, K_LOST = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       sel_valid = 1'b0;
    logic       use6 = 1'b0;
    logic [2:0] sel_slot = 3'd0;
    logic [6:0] cap = 7'd0;
    logic       uc_txd0 = 1'b1;
    logic [6:0] slot_rx = 7'h7f;

    logic       uc_rxd0, busy, sel_ack, sel_err, sel_forced, link_lost;
    logic [6:0] slot_tx;
    logic [2:0] active_slot;
    logic [1:0] dbg_state;

    logic       uc_rxd0_6, busy6, ack6, err6, forced6, lost6;
    logic [5:0] slot_tx6;
    logic [2:0] active6;
    logic [1:0] dbg6;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [2:0] m_active = NONE;

    uart_slot_arbiter #(.NUM_SLOTS(7), .SEL_W(3), .GUARD_CYCLES(G), .GAP_CYCLES(GP),
                        .DRAIN_TIMEOUT(T)) dut (
        .clk(clk), .resetn(resetn), .sel_valid(sel_valid), .sel_slot(sel_slot),
        .slot_uart_capable(cap), .UC_TXD0(uc_txd0), .slot_rx(slot_rx),
        .UC_RXD0(uc_rxd0), .slot_tx(slot_tx), .active_slot(active_slot), .busy(busy),
        .sel_ack(sel_ack), .sel_err(sel_err), .sel_forced(sel_forced),
        .link_lost(link_lost), .dbg_state(dbg_state)
    );

    uart_slot_arbiter #(.NUM_SLOTS(6), .SEL_W(3), .GUARD_CYCLES(G), .GAP_CYCLES(GP),
                        .DRAIN_TIMEOUT(T)) dut6 (
        .clk(clk), .resetn(resetn), .sel_valid(sel_valid & use6), .sel_slot(sel_slot),
        .slot_uart_capable(cap[5:0]), .UC_TXD0(uc_txd0), .slot_rx(slot_rx[5:0]),
        .UC_RXD0(uc_rxd0_6), .slot_tx(slot_tx6), .active_slot(active6), .busy(busy6),
        .sel_ack(ack6), .sel_err(err6), .sel_forced(forced6),
        .link_lost(lost6), .dbg_state(dbg6)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    function automatic logic [31:0] pack(input int kind, input logic [2:0] slot, input int at);
        logic [31:0] v;
        v = {kind[3:0], 1'b0, slot, at[23:0]};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [2:0] slot, input int at);
        exp_q.push_back(pack(kind, slot, at));
    endtask

    task automatic mon_pop(input int kind);
        logic [31:0] got, want;
        got = pack(kind, active_slot, cyc);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d slot=%0d cycle=%0d want none", kind, active_slot, cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL event: got kind=%0d slot=%0d cycle=%0d want kind=%0d slot=%0d cycle=%0d",
                         kind, active_slot, cyc, want[31:28], want[26:24], want[23:0]);
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (link_lost)  mon_pop(K_LOST);
        if (sel_forced) mon_pop(K_FORCED);
        if (sel_err)    mon_pop(K_ERR);
        if (sel_ack)    mon_pop(K_ACK);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input logic [2:0] slot);
        sel_valid = 1'b1;
        sel_slot  = slot;
        tick();
        sel_valid = 1'b0;
    endtask

    // Reference model: outcome and completion cycle of a request issued while quiescent
    // with all lines idle. The request is sampled at edge e0.
    task automatic request(input logic [2:0] slot, output int done);
        int e0;
        e0 = cyc + 1;
        if (slot == NONE) begin
            if (m_active == NONE) done = e0;
            else                  done = e0 + G + GP + 2;
            push(K_ACK, NONE, done);
            m_active = NONE;
        end else if (!cap[slot]) begin
            done = e0;
            push(K_ERR, m_active, done);
        end else if (slot == m_active) begin
            done = e0;
            push(K_ACK, slot, done);
        end else begin
            done = (m_active == NONE) ? e0 + GP + 1 : e0 + G + GP + 2;
            push(K_ACK, slot, done);
            m_active = slot;
        end
        strobe(slot);
    endtask

    task automatic settle(input string name, input int done);
        while (cyc < done + 2) tick();
        check({name, "_queue"}, exp_q.size(), 0);
        check({name, "_active"}, active_slot, m_active);
        check({name, "_busy"}, busy, 1'b0);
    endtask

    task automatic drive_toggle(input int n, input logic [2:0] slot);
        sel_valid = 1'b1;
        sel_slot  = slot;
        for (int j = 0; j < n; j++) begin
            uc_txd0 = ((j / 3) % 2 == 1) ? 1'b0 : 1'b1;
            tick();
            sel_valid = 1'b0;
        end
        uc_txd0 = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done, c, e0, n, last;
        logic       tx;
        logic [6:0] rx, exp_tx;
        logic [2:0] s;

        resetn = 1'b0;
        repeat (3) tick();
        check("rst_active", active_slot, NONE);
        check("rst_slot_tx", slot_tx, 7'h7f);
        check("rst_rxd", uc_rxd0, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {sel_ack, sel_err, sel_forced, link_lost}, 4'b0);
        check("rst_state", dbg_state, 2'd0);
        check("rst6_active", active6, NONE);
        resetn = 1'b1;
        tick();

        // First connection from NONE, then TX/RX passthrough.
        cap = 7'b0000101;
        request(3'd2, done);
        check("gap_busy", busy, 1'b1);
        settle("connect2", done);
        for (int k = 0; k < 12; k++) begin
            tx = 1'($urandom_range(0, 1));
            rx = 7'($urandom);
            uc_txd0 = tx;
            slot_rx = rx;
            tick();
            exp_tx = 7'h7f;
            exp_tx[2] = tx;
            check("pass_tx", slot_tx, exp_tx);
            check("pass_rx", uc_rxd0, rx[2]);
        end
        uc_txd0 = 1'b1;
        slot_rx = 7'h7f;
        tick();

        // Idle switch 2 -> 0, then 0 -> 2 while TX toggles for a random length.
        request(3'd0, done);
        settle("idle_sw0", done);
        c = cyc;
        e0 = c + 1;
        n = $urandom_range(12, 24);
        last = e0;
        for (int j = 0; j < n; j++) if ((j / 3) % 2 == 1) last = c + j + 1;
        done = last + G + GP + 2;
        push(K_ACK, 3'd2, done);
        m_active = 3'd2;
        drive_toggle(n, 3'd2);
        check("drain_hold_active", active_slot, 3'd0);
        check("drain_hold_busy", busy, 1'b1);
        settle("toggle_sw2", done);

        // Forced switch: TX never idles long enough.
        c = cyc;
        e0 = c + 1;
        push(K_FORCED, NONE, e0 + T + 1);
        done = e0 + T + 1 + GP + 1;
        push(K_ACK, 3'd0, done);
        m_active = 3'd0;
        drive_toggle(T + GP + 8, 3'd0);
        settle("forced_sw0", done);

        // Rejections: incapable slot, request while busy, out-of-range slot.
        request(3'd5, done);
        settle("rej_incap", done);
        c = cyc;
        e0 = c + 1;
        push(K_ERR, 3'd0, e0 + 1);
        done = e0 + G + GP + 2;
        push(K_ACK, 3'd2, done);
        m_active = 3'd2;
        sel_valid = 1'b1;
        sel_slot = 3'd2;
        tick();
        sel_slot = NONE;
        tick();
        sel_valid = 1'b0;
        check("rej_busy_active", active_slot, 3'd0);
        settle("rej_busy", done);
        use6 = 1'b1;
        request(3'd6, done);
        use6 = 1'b0;
        check("rej6_err", err6, 1'b1);
        tick();
        check("rej6_active", active6, NONE);
        check("rej6_state", dbg6, 2'd0);
        settle("rej_range", done);

        // Capability loss with a simultaneous request.
        c = cyc;
        e0 = c + 1;
        push(K_LOST, NONE, e0);
        push(K_ERR, NONE, e0);
        cap[2] = 1'b0;
        strobe(3'd0);
        check("lost_busy", busy, 1'b1);
        m_active = NONE;
        settle("lost", e0 + GP + 1);
        check("lost_state", dbg_state, 2'd0);

        // Random requests against the reference model.
        for (int k = 0; k < 10; k++) begin
            cap = 7'($urandom);
            if (m_active != NONE) cap[m_active] = 1'b1;
            s = 3'($urandom_range(0, 7));
            request(s, done);
            settle("rand", done);
        end

        // Reset asserted mid-DRAIN.
        cap = 7'b0000101;
        if (m_active != NONE) cap[m_active] = 1'b1;
        if (m_active != 3'd2) begin
            request(3'd2, done);
            settle("pre_rst", done);
        end
        cap = 7'b0000101;
        slot_rx = 7'h7b;
        sel_valid = 1'b1;
        sel_slot = 3'd0;
        for (int j = 0; j < 6; j++) begin
            uc_txd0 = ((j / 3) % 2 == 1) ? 1'b0 : 1'b1;
            tick();
            sel_valid = 1'b0;
        end
        check("mid_drain_state", dbg_state, 2'd2);
        check("mid_drain_rxd", uc_rxd0, 1'b0);
        resetn = 1'b0;
        tick();
        check("rst2_active", active_slot, NONE);
        check("rst2_slot_tx", slot_tx, 7'h7f);
        check("rst2_rxd", uc_rxd0, 1'b1);
        check("rst2_busy", busy, 1'b0);
        resetn = 1'b1;
        uc_txd0 = 1'b1;
        slot_rx = 7'h7f;
        m_active = NONE;
        repeat (3) tick();
        check("rst2_state", dbg_state, 2'd0);
        check("end_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
